// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch stage, the hazard unit, EX redirect, instruction memory and
// the IF/ID consumer. The master modport is the fetch unit itself.
interface if_fetch_unit_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] inst_address;
   logic [31:0] instruction_in;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instruction;
   logic        ifid_valid;
   logic [1:0]  fetch_fault;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, instruction_in,
      output inst_address, ifid_pc, ifid_instruction, ifid_valid, fetch_fault
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, instruction_in,
      input  inst_address, ifid_pc, ifid_instruction, ifid_valid, fetch_fault
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: drives the fetch address from the PC,
// captures {pc, instruction}, and handles stall, flush, branch redirect and sticky fetch faults.
module if_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned MEM_BYTES = 121,
   parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset_n,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   localparam logic [1:0] FaultNone      = 2'b00;
   localparam logic [1:0] FaultMisalign  = 2'b01;
   localparam logic [1:0] FaultRange     = 2'b10;
   // pc > MEM_BYTES-4 is the same test as pc+3 > MEM_BYTES-1 but cannot overflow near 2^64.
   localparam logic [63:0] LastLegalPc   = 64'(MEM_BYTES) - 64'd4;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_insn_q, ifid_insn_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [1:0]  fault_q, fault_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_insn_d  = ifid_insn_q;
      ifid_valid_d = ifid_valid_q;
      fault_d      = fault_q;

      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (bus.redirect_valid) begin
               ifid_valid_d = 1'b0;
               ifid_insn_d  = NOP_INSN;
               if (bus.redirect_pc[1:0] != 2'b00) begin
                  fault_d = FaultMisalign;
                  state_d = StHalt;
               end else begin
                  pc_d = bus.redirect_pc;
               end
            end else if (pc_q > LastLegalPc) begin
               ifid_valid_d = 1'b0;
               ifid_insn_d  = NOP_INSN;
               fault_d      = FaultRange;
               state_d      = StHalt;
            end else if (bus.stall) begin
               if (bus.flush) begin
                  ifid_valid_d = 1'b0;
                  ifid_insn_d  = NOP_INSN;
               end
            end else if (bus.flush) begin
               ifid_valid_d = 1'b0;
               ifid_insn_d  = NOP_INSN;
               pc_d         = pc_q + 64'd4;
            end else begin
               ifid_pc_d    = pc_q;
               ifid_insn_d  = bus.instruction_in;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 64'd4;
            end
         end
         StHalt: begin
            ifid_valid_d = 1'b0;
            ifid_insn_d  = NOP_INSN;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StBoot;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 64'd0;
         ifid_insn_q  <= NOP_INSN;
         ifid_valid_q <= 1'b0;
         fault_q      <= FaultNone;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_insn_q  <= ifid_insn_d;
         ifid_valid_q <= ifid_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.inst_address     = pc_q;
   assign bus.ifid_pc          = ifid_pc_q;
   assign bus.ifid_instruction = ifid_insn_q;
   assign bus.ifid_valid       = ifid_valid_q;
   assign bus.fetch_fault      = fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: combinational byte memory model plus a per-cycle scoreboard of
// expected {pc, IF/ID, fault} pushed as each cycle's stimulus is driven.
module tb_if_fetch_unit;

   localparam logic [31:0] Nop      = 32'h0000_0013;
   localparam int unsigned MemBytes = 121;

   typedef struct {
      logic [63:0] pc;
      logic        valid;
      logic [63:0] ipc;
      logic [31:0] insn;
      logic [1:0]  fault;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   if_fetch_unit_if bus ();

   if_fetch_unit #(
      .RESET_PC  (64'h0),
      .MEM_BYTES (MemBytes),
      .NOP_INSN  (Nop)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return (a < 64'(MemBytes)) ? ((lo * 8'd7) ^ 8'hA5) : 8'h00;
   endfunction

   function automatic logic [31:0] w(input logic [63:0] a);
      return {mem_byte(a + 64'd3), mem_byte(a + 64'd2), mem_byte(a + 64'd1), mem_byte(a)};
   endfunction

   always_comb bus.instruction_in = w(bus.inst_address);

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic v, input logic [63:0] ipc,
                           input logic [31:0] insn, input logic [1:0] ff);
      exp_t e;
      e.pc = pc; e.valid = v; e.ipc = ipc; e.insn = insn; e.fault = ff;
      sb_q.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      check_val({tag, ".pc"}, bus.inst_address, e.pc);
      check_val({tag, ".valid"}, 64'(bus.ifid_valid), 64'(e.valid));
      check_val({tag, ".ifid_pc"}, bus.ifid_pc, e.ipc);
      check_val({tag, ".insn"}, 64'(bus.ifid_instruction), 64'(e.insn));
      check_val({tag, ".fault"}, 64'(bus.fetch_fault), 64'(e.fault));
   endtask

   task automatic step(input string tag, input logic st, input logic fl, input logic rv,
                       input logic [63:0] rpc, input logic [63:0] pc, input logic v,
                       input logic [63:0] ipc, input logic [31:0] insn, input logic [1:0] ff);
      bus.stall          = st;
      bus.flush          = fl;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      push_exp(pc, v, ipc, insn, ff);
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   // Asserted between edges so the asynchronous path is what clears the state.
   task automatic do_reset(input string tag);
      #2;
      reset_n            = 1'b0;
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'd0;
      #1;
      push_exp(64'd0, 1'b0, 64'd0, Nop, 2'b00);
      compare_out({tag, ".async"});
      @(posedge clk);
      #1;
      push_exp(64'd0, 1'b0, 64'd0, Nop, 2'b00);
      compare_out({tag, ".held"});
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'd0;

      do_reset("rst0");
      step("boot0", 0, 0, 0, 64'h0, 64'h00, 0, 64'h00, Nop, 2'b00);
      step("t1a",   0, 0, 0, 64'h0, 64'h04, 1, 64'h00, w(64'h00), 2'b00);
      step("t1b",   0, 0, 0, 64'h0, 64'h08, 1, 64'h04, w(64'h04), 2'b00);
      step("t2s0",  1, 0, 0, 64'h0, 64'h08, 1, 64'h04, w(64'h04), 2'b00);
      step("t2s1",  1, 0, 0, 64'h0, 64'h08, 1, 64'h04, w(64'h04), 2'b00);
      step("t2res", 0, 0, 0, 64'h0, 64'h0C, 1, 64'h08, w(64'h08), 2'b00);
      step("t2n",   0, 0, 0, 64'h0, 64'h10, 1, 64'h0C, w(64'h0C), 2'b00);
      step("t3rd",  0, 0, 1, 64'h50, 64'h50, 0, 64'h0C, Nop, 2'b00);
      step("t3n",   0, 0, 0, 64'h0, 64'h54, 1, 64'h50, w(64'h50), 2'b00);
      step("flush", 0, 1, 0, 64'h0, 64'h58, 0, 64'h50, Nop, 2'b00);
      step("n58",   0, 0, 0, 64'h0, 64'h5C, 1, 64'h58, w(64'h58), 2'b00);
      step("stfl",  1, 1, 0, 64'h0, 64'h5C, 0, 64'h58, Nop, 2'b00);
      step("t4",    1, 1, 1, 64'h20, 64'h20, 0, 64'h58, Nop, 2'b00);
      step("t4n",   0, 0, 0, 64'h0, 64'h24, 1, 64'h20, w(64'h20), 2'b00);
      step("t5",    0, 0, 1, 64'h52, 64'h24, 0, 64'h20, Nop, 2'b01);
      step("t5h0",  0, 0, 0, 64'h0, 64'h24, 0, 64'h20, Nop, 2'b01);
      step("t5h1",  0, 0, 1, 64'h40, 64'h24, 0, 64'h20, Nop, 2'b01);

      do_reset("rst1");
      step("boot1", 0, 0, 0, 64'h0, 64'h00, 0, 64'h00, Nop, 2'b00);
      step("t6rd",  0, 0, 1, 64'h70, 64'h70, 0, 64'h00, Nop, 2'b00);
      step("t6a",   0, 0, 0, 64'h0, 64'h74, 1, 64'h70, w(64'h70), 2'b00);
      step("t6last",0, 0, 0, 64'h0, 64'h78, 1, 64'h74, w(64'h74), 2'b00);
      step("t6oor", 0, 0, 0, 64'h0, 64'h78, 0, 64'h74, Nop, 2'b10);
      step("t6h",   0, 1, 1, 64'h53, 64'h78, 0, 64'h74, Nop, 2'b10);

      do_reset("rst2");
      step("boot2", 0, 0, 0, 64'h0, 64'h00, 0, 64'h00, Nop, 2'b00);
      step("r2a",   0, 0, 0, 64'h0, 64'h04, 1, 64'h00, w(64'h00), 2'b00);
      step("r2b",   0, 0, 0, 64'h0, 64'h08, 1, 64'h04, w(64'h04), 2'b00);
      do_reset("rst3");
      step("boot3", 0, 0, 0, 64'h0, 64'h00, 0, 64'h00, Nop, 2'b00);
      step("r3a",   0, 0, 0, 64'h0, 64'h04, 1, 64'h00, w(64'h00), 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
